// File: rtl/ahb_iprefetch_pkg.sv
// Shared definitions for the AHB-Lite instruction prefetcher: bus encodings,
// controller states and a small sizing helper.
package ahb_iprefetch_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ERROR = 2'b10
  } ipf_state_e;

  // Occupancy counters must be able to hold the value DEPTH itself.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ahb_iprefetch_fifo.sv
// Power-of-two circular FIFO holding {instruction, address} entries for the
// prefetcher; clear wins over push and pop in the same cycle.
module ipf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_iprefetch.sv
// AHB-Lite instruction prefetcher: streams sequential word reads into a small
// FIFO, supports redirect (flush) and parks on bus errors until redirected.
module ahb_iprefetch
  import ahb_iprefetch_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          en,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr_data,
  output logic [AW-1:0] instr_addr,
  output logic          fetch_err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  localparam int CW = count_width(DEPTH);
  localparam int SW = CW + 1;
  localparam int FW = 32 + AW;

  ipf_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] haddr_q;
  logic [1:0]    htrans_q;
  logic          ap_discard_q;
  logic          dp_valid_q;
  logic [AW-1:0] dp_addr_q;
  logic          dp_discard_q;
  logic          fetch_err_q;

  logic          ap_active;
  logic          ap_accept;
  logic          ap_stall;
  logic          dp_done;
  logic          dp_stays;
  logic          err_first;
  logic          push;
  logic          pop;
  logic          inflight_after;
  logic          can_issue;
  logic [CW-1:0] fifo_count;
  logic [SW-1:0] count_after;
  logic [FW-1:0] fifo_rdata;
  logic [AW-1:0] flush_ptr;
  logic          unused_addr_bits;

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HSIZE  = HSIZE_WORD;
  assign HWRITE = 1'b0;
  assign HWDATA = '0;

  assign fetch_err        = fetch_err_q;
  assign flush_ptr        = {flush_addr[AW-1:2], 2'b00};
  assign unused_addr_bits = ^flush_addr[1:0];

  assign ap_active = (htrans_q == HTRANS_NONSEQ);
  assign ap_accept = ap_active && HREADY;
  assign ap_stall  = ap_active && !HREADY;
  assign dp_done   = dp_valid_q && HREADY;
  assign dp_stays  = dp_valid_q && !HREADY;
  assign err_first = dp_valid_q && HRESP && !HREADY;

  assign push = dp_done && !HRESP && !dp_discard_q;
  assign pop  = instr_valid && instr_ready;

  // Issue only if the FIFO can absorb every beat in flight after this edge
  // plus the one about to be driven, so a push can never find the FIFO full.
  assign inflight_after = ap_accept || dp_stays;
  assign count_after    = SW'(fifo_count) + SW'(push) - SW'(pop);
  assign can_issue      = en && (state_q == ST_FETCH) &&
                          ((count_after + SW'(inflight_after)) < SW'(DEPTH));

  ipf_fifo #(
    .DEPTH(DEPTH),
    .W    (FW)
  ) u_fifo (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .push (push),
    .pop  (pop),
    .clear(flush),
    .wdata({HRDATA, dp_addr_q}),
    .rdata(fifo_rdata),
    .count(fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr_data  = fifo_rdata[FW-1:AW];
  assign instr_addr  = fifo_rdata[AW-1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      haddr_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      ap_discard_q <= 1'b0;
      dp_valid_q   <= 1'b0;
      dp_addr_q    <= '0;
      dp_discard_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      if (ap_accept) begin
        dp_valid_q   <= 1'b1;
        dp_addr_q    <= haddr_q;
        dp_discard_q <= ap_discard_q || flush;
      end else if (dp_done) begin
        dp_valid_q   <= 1'b0;
        dp_discard_q <= 1'b0;
      end else if (dp_valid_q && (flush || err_first)) begin
        dp_discard_q <= 1'b1;
      end

      // A stalled NONSEQ must stay on the bus through a redirect; it is
      // tagged so its data is dropped once it finally completes.
      if (flush) begin
        state_q     <= ST_FETCH;
        fetch_err_q <= 1'b0;
        ptr_q       <= flush_ptr;
        if (ap_stall && !err_first) begin
          ap_discard_q <= 1'b1;
        end else begin
          htrans_q     <= HTRANS_IDLE;
          ap_discard_q <= 1'b0;
        end
      end else if (err_first) begin
        state_q      <= ST_ERROR;
        fetch_err_q  <= 1'b1;
        htrans_q     <= HTRANS_IDLE;
        ap_discard_q <= 1'b0;
      end else if (ap_stall) begin
        htrans_q <= htrans_q;
      end else if (can_issue) begin
        htrans_q     <= HTRANS_NONSEQ;
        haddr_q      <= ptr_q;
        ptr_q        <= ptr_q + AW'(4);
        ap_discard_q <= 1'b0;
      end else begin
        htrans_q     <= HTRANS_IDLE;
        ap_discard_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_iprefetch.sv
// Directed bench for ahb_iprefetch with a simple AHB slave model that returns
// {~addr, addr}, and can insert wait states or a two-cycle error response.
module tb_ahb_iprefetch;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          HCLK;
  logic          HRESETn;
  logic          en;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_addr;
  logic          fetch_err;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HRESP;

  int total = 0;
  int bad   = 0;

  logic          sdp;
  logic          serr;
  logic [AW-1:0] saddr;
  int            swait;
  int            waits_cfg;
  logic          err_en;
  logic [AW-1:0] err_addr;
  logic [AW-1:0] issued [$];
  logic [AW-1:0] held;

  ahb_iprefetch #(.AW(AW), .DEPTH(DEPTH)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .en         (en),
    .flush      (flush),
    .flush_addr (flush_addr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data (instr_data),
    .instr_addr (instr_addr),
    .fetch_err  (fetch_err),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Slave: one data phase at a time, wait states counted down while HREADY=0.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sdp   <= 1'b0;
      serr  <= 1'b0;
      saddr <= '0;
      swait <= 0;
    end else if (HREADY) begin
      if (HTRANS == 2'b10) begin
        sdp   <= 1'b1;
        saddr <= HADDR;
        serr  <= err_en && (HADDR == err_addr);
        swait <= (err_en && (HADDR == err_addr)) ? 1 : waits_cfg;
      end else begin
        sdp   <= 1'b0;
        serr  <= 1'b0;
        swait <= 0;
      end
    end else if (swait > 0) begin
      swait <= swait - 1;
    end
  end

  assign HREADY = !sdp || (swait == 0);
  assign HRESP  = sdp && serr;
  assign HRDATA = sdp ? {~saddr, saddr} : 32'h0;

  always @(posedge HCLK) begin
    if (HRESETn && HTRANS == 2'b10 && HREADY) issued.push_back(HADDR);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=still running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic [AW-1:0] fa, input logic e, input logic r);
    flush       = f;
    flush_addr  = fa;
    en          = e;
    instr_ready = r;
    @(negedge HCLK);
  endtask

  task automatic quiesce();
    repeat (12) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic waitValid(input string tag, input int bound);
    int n;
    n = 0;
    while (!instr_valid && n < bound) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
      n++;
    end
    checkOutput(tag, 64'(instr_valid), 64'h1);
  endtask

  initial begin
    int n;
    HRESETn = 1'b0; en = 1'b0; flush = 1'b0; flush_addr = '0; instr_ready = 1'b0;
    waits_cfg = 0; err_en = 1'b0; err_addr = '0; held = '0;
    repeat (2) @(negedge HCLK);
    checkOutput("rst_htrans", 64'(HTRANS), 64'h0);
    checkOutput("rst_haddr", 64'(HADDR), 64'h0);
    checkOutput("rst_valid", 64'(instr_valid), 64'h0);
    checkOutput("rst_data", 64'(instr_data), 64'h0);
    checkOutput("rst_addr", 64'(instr_addr), 64'h0);
    checkOutput("rst_err", 64'(fetch_err), 64'h0);
    HRESETn = 1'b1;
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("idle_no_fetch", 64'(HTRANS), 64'h0);

    $display("[TB] stream from 0x0100");
    issued.delete();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b1);
    checkOutput("lat_c1", 64'(instr_valid), 64'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("lat_c2", 64'(instr_valid), 64'h0);
    checkOutput("first_nonseq", 64'(HTRANS), 64'h2);
    checkOutput("first_haddr", 64'(HADDR), 64'h0100);
    checkOutput("hsize", 64'(HSIZE), 64'h2);
    checkOutput("hwrite", 64'(HWRITE), 64'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("lat_c3", 64'(instr_valid), 64'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("lat_valid", 64'(instr_valid), 64'h1);
    checkOutput("head0_addr", 64'(instr_addr), 64'h0100);
    checkOutput("head0_data", 64'(instr_data), 64'hFEFF_0100);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("head1_valid", 64'(instr_valid), 64'h1);
    checkOutput("head1_addr", 64'(instr_addr), 64'h0104);
    checkOutput("hwdata", 64'(HWDATA), 64'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("head2_valid", 64'(instr_valid), 64'h1);
    checkOutput("head2_addr", 64'(instr_addr), 64'h0108);
    checkOutput("iss0", 64'(issued[0]), 64'h0100);
    checkOutput("iss1", 64'(issued[1]), 64'h0104);

    $display("[TB] backpressure at 0x0300");
    quiesce();
    issued.delete();
    applyStimulus(1'b1, 16'h0300, 1'b1, 1'b0);
    repeat (9) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("bp_issued", 64'(issued.size()), 64'd4);
    checkOutput("bp_idle", 64'(HTRANS), 64'h0);
    checkOutput("bp_head", 64'(instr_addr), 64'h0300);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("bp_one_more", 64'(issued.size()), 64'd5);
    checkOutput("bp_new_addr", 64'(issued[4]), 64'h0310);
    checkOutput("bp_idle2", 64'(HTRANS), 64'h0);
    checkOutput("bp_head2", 64'(instr_addr), 64'h0304);

    $display("[TB] redirect during held address phase");
    waits_cfg = 2;
    quiesce();
    applyStimulus(1'b1, 16'h0400, 1'b1, 1'b1);
    n = 0;
    while (!(HTRANS == 2'b10 && !HREADY) && n < 20) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
      n++;
    end
    checkOutput("hold_found", 64'(HTRANS == 2'b10 && !HREADY), 64'h1);
    held = HADDR;
    applyStimulus(1'b1, 16'h0200, 1'b1, 1'b1);
    checkOutput("hold_htrans", 64'(HTRANS), 64'h2);
    checkOutput("hold_haddr", 64'(HADDR), 64'(held));
    issued.delete();
    waitValid("redir_valid", 40);
    checkOutput("redir_addr", 64'(instr_addr), 64'h0200);
    checkOutput("redir_data", 64'(instr_data), 64'hFDFF_0200);
    checkOutput("redir_iss0", 64'(issued[0]), 64'(held));
    checkOutput("redir_iss1", 64'(issued[1]), 64'h0200);

    $display("[TB] error response on 0x0108");
    waits_cfg = 0;
    quiesce();
    err_en = 1'b1;
    err_addr = 16'h0108;
    issued.delete();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0);
    n = 0;
    while (!HRESP && n < 20) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("err_seen", 64'(HRESP), 64'h1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("err_idle", 64'(HTRANS), 64'h0);
    checkOutput("err_flag", 64'(fetch_err), 64'h1);
    repeat (5) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("err_no_issue", 64'(HTRANS), 64'h0);
    checkOutput("err_issued", 64'(issued.size()), 64'd3);
    checkOutput("err_valid", 64'(instr_valid), 64'h1);
    checkOutput("err_head", 64'(instr_addr), 64'h0100);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("err_pop1_addr", 64'(instr_addr), 64'h0104);
    checkOutput("err_pop1_data", 64'(instr_data), 64'hFEFB_0104);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("err_drained", 64'(instr_valid), 64'h0);
    err_en = 1'b0;
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    checkOutput("err_cleared", 64'(fetch_err), 64'h0);
    waitValid("recover_valid", 10);
    checkOutput("recover_addr", 64'(instr_addr), 64'h0000);
    checkOutput("recover_data", 64'(instr_data), 64'hFFFF_0000);

    $display("[TB] address wrap at 0xFFF8");
    quiesce();
    issued.delete();
    applyStimulus(1'b1, 16'hFFF8, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("wrap0", 64'(issued[0]), 64'hFFF8);
    checkOutput("wrap1", 64'(issued[1]), 64'hFFFC);
    checkOutput("wrap2", 64'(issued[2]), 64'h0000);
    checkOutput("wrap3", 64'(issued[3]), 64'h0004);

    $display("[TB] reset mid-transfer");
    quiesce();
    issued.delete();
    applyStimulus(1'b1, 16'h0500, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("pre_rst_valid", 64'(instr_valid), 64'h1);
    checkOutput("pre_rst_busy", 64'(HTRANS), 64'h2);
    HRESETn = 1'b0;
    #1;
    checkOutput("rst_now_valid", 64'(instr_valid), 64'h0);
    checkOutput("rst_now_htrans", 64'(HTRANS), 64'h0);
    checkOutput("rst_now_haddr", 64'(HADDR), 64'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    issued.delete();
    repeat (8) applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("post_rst_valid", 64'(instr_valid), 64'h0);
    checkOutput("post_rst_htrans", 64'(HTRANS), 64'h0);
    checkOutput("post_rst_issued", 64'(issued.size()), 64'd0);
    checkOutput("post_rst_err", 64'(fetch_err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
